// File: rtl/image_capture_pkg.sv
`default_nettype none
// ============================================================================
// image_capture_pkg : frame-buffer geometry shared with the dual-port RAM,
//                     plus the capture FSM state encoding.
// Revision 1.0
// ============================================================================
package image_capture_pkg;

  localparam int SCREEN_WIDTH_DEF  = 176;
  localparam int SCREEN_HEIGHT_DEF = 144;
  localparam int ADDR_W            = 15;

  localparam logic [1:0] ST_WAIT_FRAME  = 2'd0;
  localparam logic [1:0] ST_LINE_IDLE   = 2'd1;
  localparam logic [1:0] ST_LINE_ACTIVE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/image_capture_rgb565_to_rgb332.sv
`default_nettype none
// ============================================================================
// rgb565_to_rgb332 : packs the most significant colour bits of an RGB565
//                    byte pair into one RGB332 frame-buffer byte.
// Revision 1.0
// ============================================================================
module rgb565_to_rgb332 (
  input  logic [2:0] red_msb,
  input  logic [2:0] green_msb,
  input  logic [1:0] blue_msb,
  output logic [7:0] rgb332
);

  assign rgb332 = {red_msb, green_msb, blue_msb};

endmodule
`default_nettype wire

// File: rtl/image_capture.sv
`default_nettype none
// ============================================================================
// image_capture : camera byte stream (RGB565, high byte first) to RGB332
//                 frame-buffer write port with x/y addressing.
// Revision 1.0
// ============================================================================
module image_capture
  import image_capture_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic [7:0]        pixel_data,
  output logic              frame_done
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]     X_MAX   = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     Y_MAX   = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(SCREEN_WIDTH);

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              phase_q, phase_d;
  logic [5:0]        hi_q, hi_d;
  logic              armed_q, armed_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        pixel_data_q, pixel_data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        pix_w;

  rgb565_to_rgb332 u_pack (
    .red_msb   (hi_q[5:3]),
    .green_msb (hi_q[2:0]),
    .blue_msb  (cam_data[4:3]),
    .rgb332    (pix_w)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    // A frame may only start after VSYNC has been seen high since reset.
    armed_d      = armed_q | VSYNC;
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    pixel_data_d = pixel_data_q;
    frame_done_d = 1'b0;

    if (VSYNC) begin
      state_d = ST_WAIT_FRAME;
      phase_d = 1'b0;
      if (state_q != ST_WAIT_FRAME && y_q != '0) frame_done_d = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_FRAME: begin
          if (armed_q) begin
            state_d = ST_LINE_IDLE;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
          end
        end
        ST_LINE_IDLE, ST_LINE_ACTIVE: begin
          if (HREF) begin
            state_d = ST_LINE_ACTIVE;
            phase_d = ~phase_q;
            if (!phase_q) begin
              hi_d = {cam_data[7:5], cam_data[2:0]};
            end else if (x_q != X_MAX) begin
              x_d = x_q + XW'(1);
              if (y_q != Y_MAX) begin
                w_en_d       = 1'b1;
                w_addr_d     = ADDR_W'(y_q) * WIDTH_A + ADDR_W'(x_q);
                pixel_data_d = pix_w;
              end
            end
          end else if (state_q == ST_LINE_ACTIVE) begin
            // End of line: any unpaired high byte is simply dropped.
            state_d = ST_LINE_IDLE;
            x_d     = '0;
            phase_d = 1'b0;
            if (y_q != Y_MAX) y_d = y_q + YW'(1);
          end
        end
        default: state_d = ST_WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_FRAME;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      armed_q      <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      pixel_data_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      armed_q      <= armed_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      pixel_data_q <= pixel_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign pixel_data = pixel_data_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_image_capture.sv
`default_nettype none
// ============================================================================
// tb_image_capture : scoreboard bench for image_capture.
// Revision 1.0
// ============================================================================
module tb_image_capture;

  localparam int W = 176;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  cam_data;
  logic [14:0] w_addr;
  logic        w_en;
  logic [7:0]  pixel_data;
  logic        frame_done;

  image_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .cam_data   (cam_data),
    .w_addr     (w_addr),
    .w_en       (w_en),
    .pixel_data (pixel_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int stamp;
  } exp_t;

  typedef struct {
    bit new_frame;
    int nbytes;
    int kind;
    int exp_writes;
  } line_vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_n = 0;
  int   wr_count = 0;
  int   fd_count = 0;
  int   exp_fd = 0;
  int   model_y = 0;
  int   last_addr = -1;
  int   held_addr = 0;
  int   held_data = 0;
  bit   in_frame = 1'b0;

  // Reference conversion from the colour fields of the RGB565 word.
  function automatic int pack_ref(int hi, int lo);
    int r5, g6, b5;
    r5 = (hi >> 3) & 31;
    g6 = ((hi & 7) << 3) | ((lo >> 5) & 7);
    b5 = lo & 31;
    return ((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (tick %0d)", name, act, req, tick_n);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    tick_n++;
    if (w_en) begin
      wr_count++;
      last_addr = int'(w_addr);
      held_addr = int'(w_addr);
      held_data = int'(pixel_data);
      check("write_was_expected", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("w_addr", int'(w_addr), e.addr);
        check("pixel_data", int'(pixel_data), e.data);
        check("write_latency", tick_n, e.stamp);
      end
    end else begin
      check("w_addr_hold", int'(w_addr), held_addr);
      check("pixel_data_hold", int'(pixel_data), held_data);
    end
    if (frame_done) fd_count++;
  endtask

  task automatic drive(bit vs, bit hr, int d);
    VSYNC    = vs;
    HREF     = hr;
    cam_data = 8'(d);
  endtask

  task automatic vsync_high(int n, bit hr, int d);
    if (in_frame && model_y > 0) exp_fd++;
    in_frame = 1'b0;
    drive(1'b1, hr, d);
    tick();
    drive(1'b1, 1'b0, 0);
    repeat (n) tick();
  endtask

  task automatic start_frame();
    vsync_high(3, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    repeat (3) tick();
    in_frame = 1'b1;
    model_y  = 0;
  endtask

  // kind 0: hi=n, lo=0x18 ; kind 1: hi=0xF8, lo=0x1F ; kind 2: random
  task automatic send_line(int nbytes, int kind, int gap);
    int hi = 0;
    int b;
    int k;
    for (int i = 0; i < nbytes; i++) begin
      k = i / 2;
      if (i % 2 == 0) begin
        b  = (kind == 0) ? (k & 255) : (kind == 1) ? 'hF8 : int'($urandom_range(0, 255));
        hi = b;
      end else begin
        b = (kind == 0) ? 'h18 : (kind == 1) ? 'h1F : int'($urandom_range(0, 255));
        if (in_frame && k < W && model_y < H)
          q.push_back('{model_y * W + k, pack_ref(hi, b), tick_n + 1});
      end
      drive(1'b0, 1'b1, b);
      tick();
    end
    drive(1'b0, 1'b0, 0);
    if (in_frame && model_y < H) model_y++;
    repeat (gap) tick();
    check("writes_outstanding", q.size(), 0);
  endtask

  line_vec_t tbl[6];

  initial begin
    int w0;
    int hi;
    tbl[0] = '{1'b1, 352, 0, 176};
    tbl[1] = '{1'b1, 400, 2, 176};
    tbl[2] = '{1'b0,   7, 2,   3};
    tbl[3] = '{1'b0,   1, 2,   0};
    tbl[4] = '{1'b0,   2, 1,   1};
    tbl[5] = '{1'b0,   9, 1,   4};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 0);
    repeat (3) tick();
    check("reset_w_en", int'(w_en), 0);
    check("reset_w_addr", int'(w_addr), 0);
    check("reset_pixel_data", int'(pixel_data), 0);
    check("reset_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;

    // Table-driven lines: pattern line, overlong line, odd byte counts.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].new_frame) start_frame();
      w0 = wr_count;
      send_line(tbl[i].nbytes, tbl[i].kind, 3);
      check("line_writes", wr_count - w0, tbl[i].exp_writes);
    end
    vsync_high(3, 1'b0, 0);
    check("frame_done_after_table", fd_count, exp_fd);

    // Full frame plus one surplus line beyond the last stored row.
    start_frame();
    w0 = wr_count;
    for (int l = 0; l < H + 1; l++) send_line(352, 1, 3);
    check("full_frame_writes", wr_count - w0, W * H);
    check("full_frame_last_addr", last_addr, W * H - 1);
    w0 = fd_count;
    vsync_high(3, 1'b0, 0);
    check("full_frame_done_pulses", fd_count - w0, 1);

    // VSYNC rises while the second pixel of line 10 is in flight.
    start_frame();
    for (int l = 0; l < 10; l++) send_line(20, 2, 2);
    w0 = wr_count;
    drive(1'b0, 1'b1, 'hF8); tick();
    q.push_back('{10 * W, pack_ref('hF8, 'h1F), tick_n + 1});
    drive(1'b0, 1'b1, 'h1F); tick();
    drive(1'b0, 1'b1, 'h84); tick();
    vsync_high(3, 1'b1, 'h21);
    check("abort_line_writes", wr_count - w0, 1);
    check("abort_frame_done", fd_count, exp_fd);
    start_frame();
    send_line(6, 2, 3);

    // Asynchronous reset in the middle of line 50.
    start_frame();
    for (int l = 0; l < 49; l++) send_line(20, 2, 2);
    hi = 'hAA;
    drive(1'b0, 1'b1, hi); tick();
    q.push_back('{49 * W, pack_ref(hi, 'h55), tick_n + 1});
    drive(1'b0, 1'b1, 'h55); tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_w_en", int'(w_en), 0);
    check("async_reset_w_addr", int'(w_addr), 0);
    check("async_reset_pixel_data", int'(pixel_data), 0);
    check("async_reset_frame_done", int'(frame_done), 0);
    q.delete();
    held_addr = 0;
    held_data = 0;
    in_frame  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    w0 = wr_count;
    for (int l = 0; l < 3; l++) send_line(20, 2, 2);
    check("post_reset_no_writes", wr_count - w0, 0);
    start_frame();
    send_line(8, 2, 3);

    // Randomized frames, including frames with no lines at all.
    for (int f = 0; f < 6; f++) begin
      int nl;
      start_frame();
      nl = int'($urandom_range(0, 5));
      for (int l = 0; l < nl; l++)
        send_line(int'($urandom_range(1, 60)), 2, int'($urandom_range(2, 5)));
    end
    vsync_high(4, 1'b0, 0);
    check("frame_done_total", fd_count, exp_fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_capture.md
IMAGE_CAPTURE -- requirements
Module: image_capture

Interface
REQ-001 Parameter SCREEN_WIDTH, default 176: active pixels stored per line.
REQ-002 Parameter SCREEN_HEIGHT, default 144: active lines stored per frame.
REQ-003 clk  input  1: camera pixel clock (PCLK); single clock, all logic on rising edge.
REQ-004 reset_n  input  1: reset, asynchronous, active-low.
REQ-005 VSYNC  input  1: camera frame sync; high = vertical blanking, low = frame active.
REQ-006 HREF  input  1: camera line valid; high = bytes on cam_data valid.
REQ-007 cam_data  input  8: camera byte, RGB565, high byte first.
REQ-008 w_addr  output  15: frame-buffer write address, y*SCREEN_WIDTH + x.
REQ-009 w_en  output  1: frame-buffer write strobe, one cycle per stored pixel.
REQ-010 pixel_data  output  8: RGB332 pixel for the frame buffer's input_data port.
REQ-011 frame_done  output  1: one-cycle pulse at end of each captured frame.

Function
REQ-012 States: WAIT_FRAME (wait for VSYNC low), LINE_IDLE (frame active, HREF low), LINE_ACTIVE (HREF high).
REQ-013 WAIT_FRAME -> LINE_IDLE on first sampled VSYNC low; x, y, byte phase cleared to 0 on entry.
REQ-014 LINE_IDLE -> LINE_ACTIVE on HREF high; LINE_ACTIVE -> LINE_IDLE on HREF low; any state -> WAIT_FRAME on VSYNC high.
REQ-015 In LINE_ACTIVE, byte phase toggles each cycle HREF is high; phase 0 byte latched as hi, phase 1 byte completes pixel.
REQ-016 pixel_data = {hi[7:5], hi[2:0], lo[4:3]} (R[4:2], G[5:3], B[4:3]).
REQ-017 w_en, w_addr, pixel_data all registered: valid together the cycle after the low byte is sampled (latency 1 clk from low byte).
REQ-018 After each completed pixel x increments; x saturates at SCREEN_WIDTH; pixels with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT produce no w_en.
REQ-019 On HREF falling edge (LINE_ACTIVE -> LINE_IDLE): y increments (saturates at SCREEN_HEIGHT), x and byte phase cleared.
REQ-020 HREF dropping after an odd byte count discards the unpaired hi byte; no write.
REQ-021 VSYNC rising mid-line: line abandoned, no partial write, state WAIT_FRAME.
REQ-022 frame_done pulses 1 cycle on the VSYNC-high transition from LINE_IDLE/LINE_ACTIVE only if y > 0; never from WAIT_FRAME.
REQ-023 w_addr computed as y*SCREEN_WIDTH + x in 15 bits; max value SCREEN_WIDTH*SCREEN_HEIGHT-1 = 25343; no wrap.
REQ-024 w_addr and pixel_data hold last value when w_en low.

Reset
REQ-025 reset_n low asynchronously forces: state WAIT_FRAME, x=0, y=0, phase=0, w_en=0, w_addr=0, pixel_data=0, frame_done=0.
REQ-026 Reset released mid-frame: block stays in WAIT_FRAME until next VSYNC high-then-low; no writes from the partial frame.

Structure
REQ-027 SCREEN_WIDTH/SCREEN_HEIGHT defaults and state encoding constants live in the shared frame-buffer package/include used by the dual-port RAM.
REQ-028 One sub-module natural: rgb565_to_rgb332 (combinational byte-pair to 8-bit pack); remainder flat.

Verification
REQ-029 Full frame 176x144, hi=0xF8, lo=0x1F every pixel -> 25344 w_en pulses, pixel_data=0xE3, last w_addr=25343, one frame_done.
REQ-030 One line, pixel n hi=n[7:0], lo=0x18 -> w_addr = 0..175, pixel_data = {n[7:5],n[2:0],2'b11}, each 1 clk after lo byte.
REQ-031 Line of 200 pixels -> exactly 176 writes, next line starts at w_addr=176.
REQ-032 HREF high for 7 bytes -> 3 writes, unpaired byte dropped, next line x=0.
REQ-033 VSYNC high after line 10, byte 3 -> no write for pixel 1, frame_done pulse, next frame first write at w_addr=0.
REQ-034 reset_n low during line 50 -> outputs 0 immediately (asynchronous); after release, no w_en until VSYNC high then low.
